tz_hour_display: RTL and testbench
==================================

# tz_hour_display

Local-time display stage for the world clock. Takes the free-running base hour count (0–23) from the 24-hour timer, applies a user-adjustable time-zone offset, and produces local hours, a day-shift flag, BCD digits in 12h or 24h form, and a multiplexed two-digit 7-segment drive. It is the consumer end of the timer's hour bus, sitting between the timer and the board display.

## Interface
- SCAN_DIV, 16: clock cycles each digit is held active on the display (≥2).
- TZ_MIN, -12: lowest allowed offset, signed hours.
- TZ_MAX, 14: highest allowed offset, signed hours.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; all registers take their reset values on the clock edge where reset=1.
- hours_in  in  5  base hour from the timer, 0–23; values 24–31 are treated as 0.
- tz_up  in  1  level input; each rising edge raises the offset by 1.
- tz_down  in  1  level input; each rising edge lowers the offset by 1.
- mode12  in  1  1 = 12-hour display, 0 = 24-hour display.
- tz_offset  out  5  current offset, two's complement.
- local_hours  out  5  local hour, 0–23.
- day_shift  out  2  00 = same day, 01 = next day, 11 = previous day.
- digit_tens  out  4  BCD tens of the displayed hour.
- digit_ones  out  4  BCD ones of the displayed hour.
- pm  out  1  1 when mode12=1 and local_hours ≥ 12; always 0 in 24h mode.
- an  out  2  digit enable, active-high one-hot: 01 = ones digit, 10 = tens digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high, for the digit selected by an.

## Operation
- Edge detect: up_prev and down_prev hold the inputs from the previous cycle. rise_up = tz_up & ~up_prev; rise_dn = tz_down & ~down_prev.
- Offset register:
  - rise_up alone: +1, saturating at TZ_MAX.
  - rise_dn alone: −1, saturating at TZ_MIN.
  - Both in the same cycle: no change.
- Stage 1 (registered): h = sanitized hours_in; s = h + tz_offset as signed 7-bit.
  - s < 0: local_hours = s+24, day_shift = 11.
  - s ≥ 24: local_hours = s−24, day_shift = 01.
  - Otherwise: local_hours = s, day_shift = 00.
- Stage 2 (registered, from stage-1 outputs and mode12):
  - 24h mode: d = local_hours; pm = 0.
  - 12h mode: d = 12 if local_hours = 0; local_hours−12 if local_hours > 12; local_hours otherwise. pm = (local_hours ≥ 12).
  - digit_tens = d/10; digit_ones = d%10.
- Scanner:
  - scan_cnt counts 0..SCAN_DIV−1 and wraps.
  - On the wrap edge, an toggles between 01 and 10.
  - seg is combinational from the registered an and digit registers: standard 0–9 patterns (0 = 0111111, 1 = 0000110, 2 = 1011011, …).
  - Leading-zero blanking: when an = 10, mode12 = 1 and digit_tens = 0, seg = 0000000.
- Reset values: tz_offset 0, local_hours 0, day_shift 00, digit_tens 0, digit_ones 0, pm 0, scan_cnt 0, an 01, seg 0111111. up_prev and down_prev reset to 0, so an input held high through reset produces one rise on the first cycle after reset.

## Timing
- A rise sampled at edge N updates tz_offset at edge N; it is visible after N.
- Change on hours_in or tz_offset → local_hours and day_shift at the next edge (1-cycle latency).
- digit_tens, digit_ones and pm follow one edge later (2 cycles from hours_in). A mode12 change appears after 1 edge.
- an period = 2·SCAN_DIV cycles; each digit is active for exactly SCAN_DIV cycles.
- Base-hour wrap 23→0 passes straight through the pipeline; no special handling.
- Reset asserted mid-operation: every register is at its reset value after that edge, and the pipeline holds stale-free zeros until refilled (2 cycles).
- Holding tz_up high for many cycles produces a single increment.

## Test plan
- Reset, then hold hours_in=0, mode12=0 → after 2 cycles: local_hours=0, day_shift=00, digits 0/0, an=01, seg=0111111; an becomes 10 after 16 cycles.
- hours_in=22; pulse tz_up 3 times (offset +3) → tz_offset=00011, local_hours=1, day_shift=01, digits 0/1.
- hours_in=2; pulse tz_down 5 times (offset −5) → tz_offset=11011, local_hours=21, day_shift=11.
- mode12=1: local_hours 0 → d=12, pm=0. local_hours 12 → 12, pm=1. local_hours 13 → 01, pm=1, tens digit blanked (seg=0000000 while an=10).
- 30 pulses of tz_up → tz_offset saturates at 14. tz_up and tz_down rising in the same cycle → offset unchanged. tz_up held high for 50 cycles → +1 only.
- hours_in=31 with offset 0 → local_hours=0. Assert reset mid-scan while an=10 → next cycle an=01, all outputs at reset values.

Source files
------------

// File: rtl/tz_hour_display.sv
// tz_hour_display
//
// Local-time display stage for the world clock. Applies a user-adjustable
// time-zone offset to the base hour from the 24-hour timer and drives a
// multiplexed two-digit 7-segment display.
//
// Ports:
//   clk_i          system clock, all state updates on the rising edge
//   reset_i        synchronous, active-high reset
//   hours_in_i     base hour 0..23 (24..31 treated as 0)
//   tz_up_i        level input, each rising edge raises the offset by 1
//   tz_down_i      level input, each rising edge lowers the offset by 1
//   mode12_i       1 = 12-hour display, 0 = 24-hour display
//   tz_offset_o    current offset, two's complement
//   local_hours_o  local hour 0..23
//   day_shift_o    00 same day, 01 next day, 11 previous day
//   digit_tens_o   BCD tens of the displayed hour
//   digit_ones_o   BCD ones of the displayed hour
//   pm_o           PM indicator (12-hour mode only)
//   an_o           one-hot digit enable: 01 ones, 10 tens
//   seg_o          segments {g,f,e,d,c,b,a}, active-high
module tz_hour_display #(
    parameter int unsigned SCAN_DIV = 16,
    parameter int          TZ_MIN   = -12,
    parameter int          TZ_MAX   = 14
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [4:0] hours_in_i,
    input  logic       tz_up_i,
    input  logic       tz_down_i,
    input  logic       mode12_i,
    output logic [4:0] tz_offset_o,
    output logic [4:0] local_hours_o,
    output logic [1:0] day_shift_o,
    output logic [3:0] digit_tens_o,
    output logic [3:0] digit_ones_o,
    output logic       pm_o,
    output logic [1:0] an_o,
    output logic [6:0] seg_o
);

    localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

    localparam logic [1:0] DaySame = 2'b00;
    localparam logic [1:0] DayNext = 2'b01;
    localparam logic [1:0] DayPrev = 2'b11;

    // ------------------------------------------------------------------
    // Offset control: edge detect and saturating up/down register
    // ------------------------------------------------------------------
    logic       up_prev_q, down_prev_q;
    logic       rise_up, rise_dn;
    logic [4:0] tz_offset_d, tz_offset_q;

    assign rise_up = tz_up_i & ~up_prev_q;
    assign rise_dn = tz_down_i & ~down_prev_q;

    always_comb begin
        tz_offset_d = tz_offset_q;
        if (rise_up && !rise_dn) begin
            if (int'($signed(tz_offset_q)) < TZ_MAX) begin
                tz_offset_d = tz_offset_q + 5'd1;
            end
        end else if (rise_dn && !rise_up) begin
            if (int'($signed(tz_offset_q)) > TZ_MIN) begin
                tz_offset_d = tz_offset_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            tz_offset_q <= 5'd0;
        end else begin
            up_prev_q   <= tz_up_i;
            down_prev_q <= tz_down_i;
            tz_offset_q <= tz_offset_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: local hour and day shift
    // ------------------------------------------------------------------
    logic [4:0]        hours_san;
    logic signed [6:0] sum_s;
    logic signed [6:0] sum_adj;
    logic [4:0]        local_hours_d, local_hours_q;
    logic [1:0]        day_shift_d, day_shift_q;

    assign hours_san = (hours_in_i > 5'd23) ? 5'd0 : hours_in_i;

    always_comb begin
        sum_s         = $signed({2'b00, hours_san}) + $signed({{2{tz_offset_q[4]}}, tz_offset_q});
        sum_adj       = sum_s;
        day_shift_d   = DaySame;
        if (sum_s < 7'sd0) begin
            sum_adj     = sum_s + 7'sd24;
            day_shift_d = DayPrev;
        end else if (sum_s >= 7'sd24) begin
            sum_adj     = sum_s - 7'sd24;
            day_shift_d = DayNext;
        end
        // Offset range keeps sum_adj within 0..23 here.
        local_hours_d = sum_adj[4:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            local_hours_q <= 5'd0;
            day_shift_q   <= DaySame;
        end else begin
            local_hours_q <= local_hours_d;
            day_shift_q   <= day_shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: 12/24h conversion and BCD split
    // ------------------------------------------------------------------
    logic [4:0] disp_hour;
    logic [3:0] digit_tens_d, digit_tens_q;
    logic [3:0] digit_ones_d, digit_ones_q;
    logic       pm_d, pm_q;

    always_comb begin
        disp_hour = local_hours_q;
        pm_d      = 1'b0;
        if (mode12_i) begin
            pm_d = (local_hours_q >= 5'd12);
            if (local_hours_q == 5'd0) begin
                disp_hour = 5'd12;
            end else if (local_hours_q > 5'd12) begin
                disp_hour = local_hours_q - 5'd12;
            end
        end

        // disp_hour never exceeds 23, so two compares cover the tens digit.
        if (disp_hour >= 5'd20) begin
            digit_tens_d = 4'd2;
            digit_ones_d = 4'(disp_hour - 5'd20);
        end else if (disp_hour >= 5'd10) begin
            digit_tens_d = 4'd1;
            digit_ones_d = 4'(disp_hour - 5'd10);
        end else begin
            digit_tens_d = 4'd0;
            digit_ones_d = disp_hour[3:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            digit_tens_q <= 4'd0;
            digit_ones_q <= 4'd0;
            pm_q         <= 1'b0;
        end else begin
            digit_tens_q <= digit_tens_d;
            digit_ones_q <= digit_ones_d;
            pm_q         <= pm_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scanner
    // ------------------------------------------------------------------
    logic [CntW-1:0] scan_cnt_d, scan_cnt_q;
    logic [1:0]      an_d, an_q;
    logic [3:0]      seg_digit;
    logic            blank;

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        an_d       = an_q;
        if (scan_cnt_q == CntLast) begin
            scan_cnt_d = '0;
            an_d       = {an_q[0], an_q[1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scan_cnt_q <= '0;
            an_q       <= 2'b01;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            an_q       <= an_d;
        end
    end

    // Leading zero of the tens digit is only suppressed in 12-hour mode.
    assign seg_digit = an_q[1] ? digit_tens_q : digit_ones_q;
    assign blank     = an_q[1] && mode12_i && (digit_tens_q == 4'd0);

    always_comb begin
        seg_o = 7'b0000000;
        if (!blank) begin
            unique case (seg_digit)
                4'd0:    seg_o = 7'b0111111;
                4'd1:    seg_o = 7'b0000110;
                4'd2:    seg_o = 7'b1011011;
                4'd3:    seg_o = 7'b1001111;
                4'd4:    seg_o = 7'b1100110;
                4'd5:    seg_o = 7'b1101101;
                4'd6:    seg_o = 7'b1111101;
                4'd7:    seg_o = 7'b0000111;
                4'd8:    seg_o = 7'b1111111;
                4'd9:    seg_o = 7'b1101111;
                default: seg_o = 7'b0000000;
            endcase
        end
    end

    assign tz_offset_o   = tz_offset_q;
    assign local_hours_o = local_hours_q;
    assign day_shift_o   = day_shift_q;
    assign digit_tens_o  = digit_tens_q;
    assign digit_ones_o  = digit_ones_q;
    assign pm_o          = pm_q;
    assign an_o          = an_q;

endmodule

// File: tb/tb_tz_hour_display.sv
// Self-checking bench for tz_hour_display: table-driven vectors through a
// scoreboard queue plus hand-written offset, scan and reset sequences.
module tb_tz_hour_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] hours_in;
    logic       tz_up, tz_down, mode12;
    logic [4:0] tz_offset, local_hours;
    logic [1:0] day_shift, an;
    logic [3:0] digit_tens, digit_ones;
    logic       pm;
    logic [6:0] seg;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tz_hour_display #(
        .SCAN_DIV (16),
        .TZ_MIN   (-12),
        .TZ_MAX   (14)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .hours_in_i    (hours_in),
        .tz_up_i       (tz_up),
        .tz_down_i     (tz_down),
        .mode12_i      (mode12),
        .tz_offset_o   (tz_offset),
        .local_hours_o (local_hours),
        .day_shift_o   (day_shift),
        .digit_tens_o  (digit_tens),
        .digit_ones_o  (digit_ones),
        .pm_o          (pm),
        .an_o          (an),
        .seg_o         (seg)
    );

    typedef struct {
        logic [4:0] hours;
        logic       mode;
        logic [4:0] lh;
        logic [1:0] day;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       pm;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic pulse_up();
        tz_up = 1'b1; step(); tz_up = 1'b0; step();
    endtask

    task automatic pulse_down();
        tz_down = 1'b1; step(); tz_down = 1'b0; step();
    endtask

    task automatic wait_an(input logic [1:0] want);
        for (int i = 0; i < 64 && an !== want; i++) step();
        chk("an_reached", int'(an), int'(want));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tz"},    tz_offset,   0);
        chk({tag, "_local"}, local_hours, 0);
        chk({tag, "_day"},   day_shift,   0);
        chk({tag, "_tens"},  digit_tens,  0);
        chk({tag, "_ones"},  digit_ones,  0);
        chk({tag, "_pm"},    pm,          0);
        chk({tag, "_an"},    an,          1);
        chk({tag, "_seg"},   seg,         7'b0111111);
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        vec_t e;
        // hours, mode12, local, day, tens, ones, pm  (offset 0)
        vecs[0]  = '{5'd0,  1'b0, 5'd0,  2'b00, 4'd0, 4'd0, 1'b0};
        vecs[1]  = '{5'd9,  1'b0, 5'd9,  2'b00, 4'd0, 4'd9, 1'b0};
        vecs[2]  = '{5'd23, 1'b0, 5'd23, 2'b00, 4'd2, 4'd3, 1'b0};
        vecs[3]  = '{5'd31, 1'b0, 5'd0,  2'b00, 4'd0, 4'd0, 1'b0};
        vecs[4]  = '{5'd24, 1'b0, 5'd0,  2'b00, 4'd0, 4'd0, 1'b0};
        vecs[5]  = '{5'd0,  1'b1, 5'd0,  2'b00, 4'd1, 4'd2, 1'b0};
        vecs[6]  = '{5'd12, 1'b1, 5'd12, 2'b00, 4'd1, 4'd2, 1'b1};
        vecs[7]  = '{5'd13, 1'b1, 5'd13, 2'b00, 4'd0, 4'd1, 1'b1};
        vecs[8]  = '{5'd11, 1'b1, 5'd11, 2'b00, 4'd1, 4'd1, 1'b0};
        vecs[9]  = '{5'd23, 1'b1, 5'd23, 2'b00, 4'd1, 4'd1, 1'b1};
        vecs[10] = '{5'd19, 1'b0, 5'd19, 2'b00, 4'd1, 4'd9, 1'b0};
        vecs[11] = '{5'd0,  1'b0, 5'd0,  2'b00, 4'd0, 4'd0, 1'b0};

        reset = 1'b1; hours_in = 5'd0; tz_up = 1'b0; tz_down = 1'b0; mode12 = 1'b0;
        step(); step();
        chk_reset_state("rst");
        reset = 1'b0;

        // Scan period: an toggles on the 16th edge after reset.
        repeat (15) step();
        chk("scan_an_15", an, 2'b01);
        step();
        chk("scan_an_16", an, 2'b10);
        chk("scan_seg_tens0_24h", seg, 7'b0111111);
        repeat (16) step();
        chk("scan_an_32", an, 2'b01);

        // Table vectors through the scoreboard
        foreach (vecs[i]) begin
            hours_in = vecs[i].hours;
            mode12   = vecs[i].mode;
            exp_q.push_back(vecs[i]);
            step(); step();
            e = exp_q.pop_front();
            chk($sformatf("v%0d_local", i), local_hours, e.lh);
            chk($sformatf("v%0d_day", i),   day_shift,   e.day);
            chk($sformatf("v%0d_tens", i),  digit_tens,  e.tens);
            chk($sformatf("v%0d_ones", i),  digit_ones,  e.ones);
            chk($sformatf("v%0d_pm", i),    pm,          e.pm);
        end

        // +3 offset: 22 -> 1 next day
        hours_in = 5'd22; mode12 = 1'b0;
        repeat (3) pulse_up();
        step(); step();
        chk("p3_tz", tz_offset, 5'b00011);
        chk("p3_local", local_hours, 1);
        chk("p3_day", day_shift, 2'b01);
        chk("p3_tens", digit_tens, 0);
        chk("p3_ones", digit_ones, 1);

        // -5 offset: 2 -> 21 previous day
        do_reset();
        hours_in = 5'd2;
        repeat (5) pulse_down();
        step(); step();
        chk("m5_tz", tz_offset, 5'b11011);
        chk("m5_local", local_hours, 21);
        chk("m5_day", day_shift, 2'b11);
        chk("m5_tens", digit_tens, 2);
        chk("m5_ones", digit_ones, 1);

        // 12h blanking of the tens digit at 13:00
        do_reset();
        hours_in = 5'd13; mode12 = 1'b1;
        step(); step();
        chk("b13_pm", pm, 1);
        wait_an(2'b10);
        chk("b13_seg_blank", seg, 7'b0000000);
        wait_an(2'b01);
        chk("b13_seg_ones", seg, 7'b0000110);
        hours_in = 5'd12;
        step(); step();
        wait_an(2'b10);
        chk("b12_seg_tens", seg, 7'b0000110);
        mode12 = 1'b0;

        // Saturation high, simultaneous edges, saturation low, held input
        do_reset();
        repeat (30) pulse_up();
        chk("sat_hi_tz", tz_offset, 5'b01110);
        hours_in = 5'd10;
        step(); step();
        chk("sat_hi_local", local_hours, 0);
        chk("sat_hi_day", day_shift, 2'b01);
        tz_up = 1'b1; tz_down = 1'b1; step();
        tz_up = 1'b0; tz_down = 1'b0; step();
        chk("both_tz", tz_offset, 5'b01110);
        repeat (3) pulse_down();
        tz_up = 1'b1; tz_down = 1'b1; step();
        tz_up = 1'b0; tz_down = 1'b0; step();
        chk("both_mid_tz", tz_offset, 5'b01011);
        repeat (30) pulse_down();
        chk("sat_lo_tz", tz_offset, 5'b10100);
        hours_in = 5'd11;
        step(); step();
        chk("sat_lo_local", local_hours, 23);
        chk("sat_lo_day", day_shift, 2'b11);
        tz_up = 1'b1;
        repeat (50) step();
        tz_up = 1'b0;
        step();
        chk("held_tz", tz_offset, 5'b10101);

        // Input held high through reset gives one rise after release
        tz_up = 1'b1;
        do_reset();
        chk("hold_rst_tz0", tz_offset, 0);
        step();
        chk("hold_rst_tz1", tz_offset, 1);
        repeat (5) step();
        chk("hold_rst_tz_stay", tz_offset, 1);
        tz_up = 1'b0;

        // Reset mid-scan while tens digit active
        hours_in = 5'd23; mode12 = 1'b0;
        step(); step();
        wait_an(2'b10);
        do_reset();
        chk_reset_state("mid");
        step();
        chk("refill_local", local_hours, 23);
        chk("refill_tens_stale", digit_tens, 0);
        step();
        chk("refill_tens", digit_tens, 2);
        chk("refill_ones", digit_ones, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
